// File: rtl/onehot_position_decoder.sv
// One-hot step bus receiver: decodes the bus to a binary position,
// checks single-bit left advance with wrap, counts wraps, flags faults.
module onehot_position_decoder #(
  parameter int WIDTH = 16,
  parameter int WRAP_CNT_W = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_bus,
  input  logic                  clear_err,
  output logic [IDX_W-1:0]      pos,
  output logic                  pos_valid,
  output logic                  step,
  output logic                  wrap,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  err,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2,
    RESYNC = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_MULTI = 2'b01;
  localparam logic [1:0] CODE_SEQ   = 2'b10;

  state_t                state, state_n;
  logic [WIDTH-1:0]      prev_bus;
  logic [IDX_W-1:0]      idx, pos_inc, pos_n;
  logic [WRAP_CNT_W-1:0] wrap_count_n;
  logic [1:0]            err_code_n;
  logic                  pos_valid_n, step_n, wrap_n, err_n;
  logic                  is_zero, is_multi, is_held, at_last;
  logic                  c_multi, c_one, accept, wrapping;

  assign is_zero  = (in_bus == '0);
  assign is_multi = ((in_bus & (in_bus - WIDTH'(1))) != '0);
  assign is_held  = (in_bus == prev_bus) && (prev_bus != '0);

  // Mutually exclusive classes; ZERO and HELD are the idle remainder
  assign c_multi = is_multi;
  assign c_one   = !is_zero && !is_multi && !is_held;

  assign at_last = (pos == IDX_W'(WIDTH - 1));
  assign pos_inc = at_last ? '0 : pos + IDX_W'(1);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_bus[i]) idx = IDX_W'(i);
    end
  end

  assign accept = (state == RESYNC) ||
                  ((state == EMPTY) && (idx == '0)) ||
                  ((state == TRACK) && (idx == pos_inc));
  assign wrapping = (state == TRACK) && at_last;

  always_comb begin
    state_n      = state;
    pos_n        = pos;
    pos_valid_n  = pos_valid;
    step_n       = 1'b0;
    wrap_n       = 1'b0;
    wrap_count_n = wrap_count;
    err_n        = err;
    err_code_n   = err_code;
    unique case (state)
      FAULT: begin
        if (clear_err) begin
          state_n     = RESYNC;
          err_n       = 1'b0;
          err_code_n  = CODE_NONE;
          pos_valid_n = 1'b0;
        end
      end
      default: begin
        unique case (1'b1)
          c_multi: begin
            state_n    = FAULT;
            err_n      = 1'b1;
            err_code_n = CODE_MULTI;
          end
          c_one: begin
            if (accept) begin
              state_n     = TRACK;
              pos_n       = idx;
              pos_valid_n = 1'b1;
              step_n      = 1'b1;
              wrap_n      = wrapping;
              if (wrapping && !(&wrap_count))
                wrap_count_n = wrap_count + WRAP_CNT_W'(1);
            end else begin
              state_n    = FAULT;
              err_n      = 1'b1;
              err_code_n = CODE_SEQ;
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      prev_bus   <= '0;
      pos        <= '0;
      pos_valid  <= 1'b0;
      step       <= 1'b0;
      wrap       <= 1'b0;
      wrap_count <= '0;
      err        <= 1'b0;
      err_code   <= CODE_NONE;
    end else begin
      state      <= state_n;
      prev_bus   <= in_bus;
      pos        <= pos_n;
      pos_valid  <= pos_valid_n;
      step       <= step_n;
      wrap       <= wrap_n;
      wrap_count <= wrap_count_n;
      err        <= err_n;
      err_code   <= err_code_n;
    end
  end

endmodule
